// File: rtl/wrr_arbiter_wdt_pkg.sv
// Shared types and defaults for the weighted round-robin arbiter.
package arb_pkg;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_t;

  localparam int ARB_N   = 4;
  localparam int ARB_CW  = 4;
  localparam int ARB_TOW = 8;

  // Index width for N requesters; never below one bit.
  function automatic int idx_w(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  localparam int ARB_IDW = idx_w(ARB_N);

endpackage

// File: rtl/wrr_arbiter_wdt_if.sv
// Requester/resource-side bundle of the arbiter.
interface wrr_arbiter_wdt_if
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int CW = ARB_CW
);
  localparam int IW = idx_w(N);

  logic [N-1:0]    req;
  logic            ack;
  logic [N*CW-1:0] weight;
  logic [N-1:0]    grant;
  logic            busy;
  logic            to_err;
  logic [IW-1:0]   err_id;

  modport master (
    output req, ack, weight,
    input  grant, busy, to_err, err_id
  );

  modport slave (
    input  req, ack, weight,
    output grant, busy, to_err, err_id
  );
endinterface

// File: rtl/wrr_arbiter_wdt_rr_pick.sv
// Rotating priority encoder: first set request at or above ptr, wrapping.
module rr_pick
  import arb_pkg::*;
#(
  parameter int N  = ARB_N,
  parameter int IW = idx_w(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] ptr_i,
  output logic [IW-1:0] win_o,
  output logic          valid_o
);
  int idx;

  // Scan from the farthest offset down so the nearest request wins last.
  always_comb begin
    win_o   = '0;
    valid_o = 1'b0;
    idx     = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr_i) + k) % N;
      if (req_i[idx]) begin
        win_o   = IW'(idx);
        valid_o = 1'b1;
      end
    end
  end
endmodule

// File: rtl/wrr_arbiter_wdt.sv
// Weighted round-robin arbiter with per-grant watchdog.
module wrr_arbiter_wdt
  import arb_pkg::*;
#(
  parameter int N       = ARB_N,
  parameter int CW      = ARB_CW,
  parameter int TOW     = ARB_TOW,
  parameter int TIMEOUT = 16
) (
  input  logic               clk_i,
  input  logic               aclr_i,
  wrr_arbiter_wdt_if.slave   bus
);
  localparam int IW = idx_w(N);

  state_t          state_q;
  logic [N-1:0]    grant_q;
  logic [IW-1:0]   owner_q;
  logic [IW-1:0]   ptr_q;
  logic [IW-1:0]   err_id_q;
  logic [CW-1:0]   cnt_q;
  logic [TOW-1:0]  wdt_q;
  logic            to_err_q;

  logic [IW-1:0]   pick_w;
  logic            pick_vld;
  logic [CW-1:0]   wt_pick;
  logic [CW-1:0]   reload_d;
  logic [IW-1:0]   ptr_next_d;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req_i   (bus.req),
    .ptr_i   (ptr_q),
    .win_o   (pick_w),
    .valid_o (pick_vld)
  );

  // Weight 0 behaves as 1, so the reload of remaining credit is max(w,1)-1.
  assign wt_pick    = bus.weight[int'(pick_w)*CW +: CW];
  assign reload_d   = (wt_pick == '0) ? '0 : wt_pick - 1'b1;
  assign ptr_next_d = (int'(owner_q) == N - 1) ? '0 : owner_q + 1'b1;

  // Arbitration FSM with credit accounting and watchdog; all outputs registered.
  always_ff @(posedge clk_i or posedge aclr_i) begin
    if (aclr_i) begin
      state_q  <= ST_IDLE;
      grant_q  <= '0;
      owner_q  <= '0;
      ptr_q    <= '0;
      err_id_q <= '0;
      cnt_q    <= '0;
      wdt_q    <= '0;
      to_err_q <= 1'b0;
    end else begin
      to_err_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (pick_vld) begin
            state_q <= ST_GRANT;
            grant_q <= {{(N-1){1'b0}}, 1'b1} << pick_w;
            owner_q <= pick_w;
            wdt_q   <= '0;
            if (pick_w == ptr_q && cnt_q != '0) begin
              cnt_q <= cnt_q - 1'b1;
            end else begin
              ptr_q <= pick_w;
              cnt_q <= reload_d;
            end
          end
        end
        ST_GRANT: begin
          if (bus.ack || !bus.req[owner_q]) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            if (cnt_q == '0) ptr_q <= ptr_next_d;
          end else if (wdt_q == TOW'(TIMEOUT - 1)) begin
            state_q  <= ST_IDLE;
            grant_q  <= '0;
            to_err_q <= 1'b1;
            err_id_q <= owner_q;
            ptr_q    <= ptr_next_d;
            cnt_q    <= '0;
          end else begin
            wdt_q <= wdt_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          grant_q <= '0;
        end
      endcase
    end
  end

  assign bus.grant  = grant_q;
  assign bus.busy   = |grant_q;
  assign bus.to_err = to_err_q;
  assign bus.err_id = err_id_q;
endmodule

// File: tb/tb_wrr_arbiter_wdt.sv
// Self-checking bench for wrr_arbiter_wdt: directed tables, corner sequences, random vs model.
module tb_wrr_arbiter_wdt;
  localparam int N       = 4;
  localparam int CW      = 4;
  localparam int TOW     = 8;
  localparam int TIMEOUT = 16;
  localparam int IW      = 2;

  logic clk;
  logic aclr;
  int   total = 0;
  int   bad   = 0;

  wrr_arbiter_wdt_if #(.N(N), .CW(CW)) bus ();

  wrr_arbiter_wdt #(.N(N), .CW(CW), .TOW(TOW), .TIMEOUT(TIMEOUT)) dut (
    .clk_i  (clk),
    .aclr_i (aclr),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [N-1:0] req;
    logic         ack;
    logic [N-1:0] grant;
  } vec_t;

  vec_t tv[$];

  // Reference model: explicit owner/pointer/credit/age bookkeeping as integers.
  bit m_open;
  int m_owner, m_ptr, m_cnt, m_age, m_err_id;
  bit m_to_err;

  task automatic model_reset();
    m_open = 0; m_owner = 0; m_ptr = 0; m_cnt = 0; m_age = 0;
    m_err_id = 0; m_to_err = 0;
  endtask

  task automatic model_step();
    int w;
    int wt;
    m_to_err = 0;
    if (!m_open) begin
      if (bus.req != '0) begin
        w = -1;
        for (int k = 0; k < N; k++)
          if (w < 0 && bus.req[(m_ptr + k) % N]) w = (m_ptr + k) % N;
        wt = int'(bus.weight[w*CW +: CW]);
        if (w == m_ptr && m_cnt > 0) m_cnt = m_cnt - 1;
        else begin
          m_ptr = w;
          m_cnt = ((wt == 0) ? 1 : wt) - 1;
        end
        m_open = 1; m_owner = w; m_age = 0;
      end
    end else if (bus.ack || !bus.req[m_owner]) begin
      m_open = 0;
      if (m_cnt == 0) m_ptr = (m_owner + 1) % N;
    end else if (m_age == TIMEOUT - 1) begin
      m_open = 0; m_to_err = 1; m_err_id = m_owner;
      m_ptr = (m_owner + 1) % N; m_cnt = 0;
    end else begin
      m_age = m_age + 1;
    end
  endtask

  function automatic logic [N-1:0] model_grant();
    return m_open ? (N'(1) << m_owner) : '0;
  endfunction

  task automatic tick();
    model_step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    aclr = 1'b1;
    model_reset();
    @(negedge clk);
    aclr = 1'b0;
  endtask

  task automatic check(input string nm, input logic [N-1:0] eg, input logic ete,
                       input logic [IW-1:0] eid, input bit chk_id);
    total++;
    if (bus.grant !== eg || bus.busy !== (|eg) || bus.to_err !== ete ||
        (chk_id && bus.err_id !== eid)) begin
      bad++;
      $display("FAIL %s: got grant=%b busy=%b to_err=%b err_id=%0d, want grant=%b busy=%b to_err=%b err_id=%0d",
               nm, bus.grant, bus.busy, bus.to_err, bus.err_id, eg, |eg, ete, eid);
    end
  endtask

  task automatic run_table(input string nm);
    for (int i = 0; i < tv.size(); i++) begin
      bus.req = tv[i].req;
      bus.ack = tv[i].ack;
      tick();
      check($sformatf("%s[%0d]", nm, i), tv[i].grant, 1'b0, '0, 1'b0);
    end
  endtask

  initial begin
    bus.req    = '0;
    bus.ack    = 1'b0;
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    aclr       = 1'b1;
    model_reset();
    #2;
    check("reset_state", '0, 1'b0, '0, 1'b1);
    @(negedge clk);
    aclr = 1'b0;

    // Equal weights, ACK held: plain rotation with an idle cycle between grants.
    tv.delete();
    tv.push_back('{4'hF, 1'b1, 4'b0001});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0010});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0100});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b1000});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0001});
    run_table("rr_w1");

    // Requester 0 weight 3: three consecutive grants before rotating.
    do_reset();
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd3};
    tv.delete();
    tv.push_back('{4'hF, 1'b1, 4'b0001});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0001});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0001});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0010});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0100});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b1000});
    tv.push_back('{4'hF, 1'b1, 4'b0000});
    tv.push_back('{4'hF, 1'b1, 4'b0001});
    run_table("wrr_w3");

    // Async reset mid-grant clears outputs without a clock edge.
    do_reset();
    bus.weight = {4'd1, 4'd1, 4'd1, 4'd1};
    bus.req = 4'b0100; bus.ack = 1'b0;
    tick();
    check("midrst_pre", 4'b0100, 1'b0, '0, 1'b0);
    #2 aclr = 1'b1;
    #1 check("midrst_async", '0, 1'b0, '0, 1'b1);
    bus.req = '0;
    #1 aclr = 1'b0;
    model_reset();
    tick();
    check("midrst_after", '0, 1'b0, '0, 1'b1);

    // Watchdog: 16 cycles of grant, then revoke with pulse and ERR_ID.
    do_reset();
    bus.req = 4'b0010; bus.ack = 1'b0;
    tick();
    check("wdt_grant", 4'b0010, 1'b0, '0, 1'b0);
    for (int i = 0; i < TIMEOUT - 1; i++) begin
      tick();
      check($sformatf("wdt_hold%0d", i), 4'b0010, 1'b0, '0, 1'b0);
    end
    tick();
    check("wdt_fire", '0, 1'b1, 2'd1, 1'b1);
    bus.req = 4'b1010;
    tick();
    check("wdt_next", 4'b1000, 1'b0, 2'd1, 1'b1);

    // ACK on the timeout cycle wins over the watchdog.
    do_reset();
    bus.req = 4'b0100; bus.ack = 1'b0;
    tick();
    for (int i = 0; i < TIMEOUT - 1; i++) tick();
    check("ackwin_hold", 4'b0100, 1'b0, '0, 1'b0);
    bus.ack = 1'b1;
    tick();
    check("ackwin_rel", '0, 1'b0, '0, 1'b1);
    bus.ack = 1'b0;

    // Abandon by dropping REQ; ACK while idle does nothing.
    do_reset();
    bus.req = 4'b0001;
    tick();
    check("abandon_grant", 4'b0001, 1'b0, '0, 1'b0);
    bus.req = '0;
    tick();
    check("abandon_rel", '0, 1'b0, '0, 1'b0);
    bus.ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("idle_ack%0d", i), '0, 1'b0, '0, 1'b1);
    end
    bus.ack = 1'b0;

    // Randomized run against the reference model.
    do_reset();
    bus.weight = N*CW'($urandom);
    bus.req = '0;
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 5) == 0) bus.req = N'($urandom);
      bus.ack = ($urandom_range(0, 6) == 0);
      if ($urandom_range(0, 63) == 0) bus.weight = N*CW'($urandom);
      if (c == 1500) do_reset();
      tick();
      check("rand", model_grant(), m_to_err, IW'(m_err_id), 1'b1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
